// File: rtl/seq_pkg.sv
// Shared types and field positions for the instruction sequencer.
package seq_pkg;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 3;
    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_LDI = 4'd1,
        OP_MOV = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_WRITE
    } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational 8-bit ALU; res[8] is the ADD carry / SUB borrow, zero otherwise.
module seq_alu
    import seq_pkg::*;
(
    input  opcode_e           op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W:0]   res
);

    always_comb begin
        res = '0;
        case (op)
            OP_MOV:  res = {1'b0, op_a};
            OP_ADD:  res = {1'b0, op_a} + {1'b0, op_b};
            // 9-bit difference: bit 8 ends up set exactly when op_a < op_b
            OP_SUB:  res = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  res = {1'b0, op_a & op_b};
            OP_OR:   res = {1'b0, op_a | op_b};
            OP_XOR:  res = {1'b0, op_a ^ op_b};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer driving an 8x8 register file: read operands, execute, write back.
// Define SEQ_FLAGS_EN to build the registered zero/carry flags; otherwise they are tied low.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [DATA_W-1:0]  d_out,
    output logic [SEL_W-1:0]   s_out,
    output logic               out_en,
    output logic [SEL_W-1:0]   s_in,
    output logic [DATA_W-1:0]  d_in,
    output logic               write_en,
    output logic               done,
    output logic               illegal,
    output logic               flag_z,
    output logic               flag_c
);

    state_e              state_q, state_d;
    opcode_e             op_q, op_d;
    logic [SEL_W-1:0]    rd_q, rd_d;
    logic [SEL_W-1:0]    rs2_q, rs2_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [SEL_W-1:0]    s_out_q, s_out_d;
    logic [SEL_W-1:0]    s_in_q, s_in_d;
    logic [DATA_W-1:0]   d_in_q, d_in_d;
    logic                ready_q, ready_d;
    logic                out_en_q, out_en_d;
    logic                write_en_q, write_en_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic [OP_W-1:0]     in_op;
    logic [DATA_W:0]     alu_res;

    assign in_op = instr[OP_LSB +: OP_W];

    // opB is never stored: in EXEC the second operand is still on d_out.
    seq_alu u_alu (
        .op   (op_q),
        .op_a (opa_q),
        .op_b (d_out),
        .res  (alu_res)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs2_d     = rs2_q;
        opa_d     = opa_q;
        s_out_d   = s_out_q;
        s_in_d    = s_in_q;
        d_in_d    = d_in_q;
        illegal_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d  = opcode_e'(in_op);
                    rd_d  = instr[RD_LSB +: SEL_W];
                    rs2_d = instr[RS2_LSB +: SEL_W];
                    if (in_op[OP_W-1]) begin
                        illegal_d = 1'b1;
                    end else if (in_op == OP_LDI) begin
                        state_d = S_WRITE;
                        s_in_d  = instr[RD_LSB +: SEL_W];
                        d_in_d  = instr[IMM_LSB +: DATA_W];
                    end else if (in_op != OP_NOP) begin
                        state_d = S_READ_A;
                        s_out_d = instr[RS1_LSB +: SEL_W];
                    end
                end
            end
            S_READ_A: begin
                state_d = S_READ_B;
                s_out_d = rs2_q;
            end
            S_READ_B: begin
                state_d = S_EXEC;
                opa_d   = d_out;
            end
            S_EXEC: begin
                state_d = S_WRITE;
                s_in_d  = rd_q;
                d_in_d  = alu_res[DATA_W-1:0];
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        ready_d    = (state_d == S_IDLE);
        out_en_d   = (state_d == S_READ_A) || (state_d == S_READ_B);
        write_en_d = (state_d == S_WRITE);
        done_d     = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            rd_q       <= '0;
            rs2_q      <= '0;
            opa_q      <= '0;
            s_out_q    <= '0;
            s_in_q     <= '0;
            d_in_q     <= '0;
            ready_q    <= 1'b1;
            out_en_q   <= 1'b0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs2_q      <= rs2_d;
            opa_q      <= opa_d;
            s_out_q    <= s_out_d;
            s_in_q     <= s_in_d;
            d_in_q     <= d_in_d;
            ready_q    <= ready_d;
            out_en_q   <= out_en_d;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

    assign instr_ready = ready_q;
    assign s_out       = s_out_q;
    assign out_en      = out_en_q;
    assign s_in        = s_in_q;
    assign d_in        = d_in_q;
    assign write_en    = write_en_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

`ifdef SEQ_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;

    // Only ALU/MOV instructions pass through EXEC, so LDI/NOP/illegal leave flags alone.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        if (state_q == S_EXEC) begin
            flag_z_d = (alu_res[DATA_W-1:0] == '0);
            flag_c_d = alu_res[DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = alu_res[DATA_W];
    assign flag_z       = 1'b0;
    assign flag_c       = 1'b0;
`endif

endmodule
